// File: rtl/hilo_muldiv_unit_pkg.sv
// Shared op codes and FSM encodings for the HI/LO multiply/divide unit.
package hilo_muldiv_unit_pkg;

  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5
  } md_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_FIN  = 2'd3
  } state_e;

  function automatic logic op_is_arith(input logic [2:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic op_is_div(input logic [2:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic op_is_signed(input logic [2:0] op);
    return (op == MD_MULT) || (op == MD_DIV);
  endfunction

endpackage

// File: rtl/muldiv_iter_core.sv
// One radix-2 step of shift-add multiply and restoring divide on a 2*WIDTH accumulator.
module muldiv_iter_core #(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH-1:0] i_acc,
  input  logic [WIDTH-1:0]   i_opnd,
  output logic [2*WIDTH-1:0] o_mul_acc,
  output logic [2*WIDTH-1:0] o_div_acc
);

  logic [WIDTH:0] w_sum;
  logic [WIDTH:0] w_rem_sh;
  logic [WIDTH:0] w_diff;

  // Multiply: acc = {partial product, remaining multiplier bits}; add then shift right.
  assign w_sum     = {1'b0, i_acc[2*WIDTH-1:WIDTH]} + (i_acc[0] ? {1'b0, i_opnd} : '0);
  assign o_mul_acc = {w_sum, i_acc[WIDTH-1:1]};

  // Divide: acc = {remainder, dividend bits/quotient}; shift left, trial subtract.
  assign w_rem_sh  = i_acc[2*WIDTH-1:WIDTH-1];
  assign w_diff    = w_rem_sh - {1'b0, i_opnd};
  assign o_div_acc = w_diff[WIDTH] ? {w_rem_sh[WIDTH-1:0], i_acc[WIDTH-2:0], 1'b0}
                                   : {w_diff[WIDTH-1:0],   i_acc[WIDTH-2:0], 1'b1};

endmodule

// File: rtl/hilo_muldiv_unit.sv
// HI/LO register file with an iterative multiply/divide engine and pipeline stall/flush.
module hilo_muldiv_unit
  import hilo_muldiv_unit_pkg::*;
#(
  parameter  int WIDTH = 32,
  localparam int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [2:0]       i_op,
  input  logic [WIDTH-1:0] i_src_a,
  input  logic [WIDTH-1:0] i_src_b,
  input  logic             i_flush,
  output logic             o_stall,
  output logic             o_done,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo
);

  state_e             r_state, w_next;
  logic [CNT_W-1:0]   r_cnt;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_opnd;
  logic [WIDTH-1:0]   r_hi, r_lo;
  logic               r_neg_lo, r_neg_hi, r_is_div, r_dz, r_done;

  logic               w_arith, w_div, w_dz, w_a_neg, w_b_neg, w_last;
  logic [WIDTH-1:0]   w_abs_a, w_abs_b;
  logic [2*WIDTH-1:0] w_mul_acc, w_div_acc, w_prod;
  logic [WIDTH-1:0]   w_quo, w_rem, w_res_hi, w_res_lo;

  assign w_arith = i_start && op_is_arith(i_op);
  assign w_div   = op_is_div(i_op);
  assign w_dz    = w_div && (i_src_b == '0);
  assign w_a_neg = op_is_signed(i_op) && i_src_a[WIDTH-1];
  assign w_b_neg = op_is_signed(i_op) && i_src_b[WIDTH-1];
  assign w_abs_a = w_a_neg ? -i_src_a : i_src_a;
  assign w_abs_b = w_b_neg ? -i_src_b : i_src_b;
  assign w_last  = (r_cnt == CNT_W'(WIDTH - 1));

  muldiv_iter_core #(.WIDTH(WIDTH)) u_core (
    .i_acc     (r_acc),
    .i_opnd    (r_opnd),
    .o_mul_acc (w_mul_acc),
    .o_div_acc (w_div_acc)
  );

  // Sign correction on the unsigned result; most-negative / -1 wraps naturally.
  assign w_prod = r_neg_lo ? -r_acc : r_acc;
  assign w_quo  = r_neg_lo ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
  assign w_rem  = r_neg_hi ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];

  always_comb begin
    w_res_hi = w_prod[2*WIDTH-1:WIDTH];
    w_res_lo = w_prod[WIDTH-1:0];
    if (r_dz) begin
      w_res_hi = r_acc[WIDTH-1:0];
      w_res_lo = '1;
    end else if (r_is_div) begin
      w_res_hi = w_rem;
      w_res_lo = w_quo;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next  = r_state;
    o_stall = 1'b0;
    if (!i_flush) begin
      case (r_state)
        S_IDLE: begin
          if (w_arith) begin
            o_stall = 1'b1;
            w_next  = w_dz ? S_FIN : (w_div ? S_DIV : S_MUL);
          end
        end
        S_MUL, S_DIV: begin
          o_stall = 1'b1;
          if (w_last) w_next = S_FIN;
        end
        S_FIN: begin
          o_stall = 1'b1;
          w_next  = S_IDLE;
        end
        default: w_next = S_IDLE;
      endcase
    end else begin
      w_next = S_IDLE;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt    <= '0;
      r_acc    <= '0;
      r_opnd   <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_neg_lo <= 1'b0;
      r_neg_hi <= 1'b0;
      r_is_div <= 1'b0;
      r_dz     <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (!i_flush) begin
        case (r_state)
          S_IDLE: begin
            if (i_start) begin
              case (i_op)
                MD_MTHI: r_hi <= i_src_a;
                MD_MTLO: r_lo <= i_src_a;
                MD_MULT, MD_MULTU: begin
                  r_acc    <= {{WIDTH{1'b0}}, w_abs_b};
                  r_opnd   <= w_abs_a;
                  r_neg_lo <= w_a_neg ^ w_b_neg;
                  r_neg_hi <= 1'b0;
                  r_is_div <= 1'b0;
                  r_dz     <= 1'b0;
                  r_cnt    <= '0;
                end
                MD_DIV, MD_DIVU: begin
                  // Divide by zero keeps the raw dividend so it can be returned in HI.
                  r_acc    <= {{WIDTH{1'b0}}, (w_dz ? i_src_a : w_abs_a)};
                  r_opnd   <= w_abs_b;
                  r_neg_lo <= w_a_neg ^ w_b_neg;
                  r_neg_hi <= w_a_neg;
                  r_is_div <= 1'b1;
                  r_dz     <= w_dz;
                  r_cnt    <= '0;
                end
                default: ;
              endcase
            end
          end
          S_MUL: begin
            r_acc <= w_mul_acc;
            r_cnt <= r_cnt + CNT_W'(1);
          end
          S_DIV: begin
            r_acc <= w_div_acc;
            r_cnt <= r_cnt + CNT_W'(1);
          end
          S_FIN: begin
            r_hi   <= w_res_hi;
            r_lo   <= w_res_lo;
            r_done <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  assign o_done = r_done;
  assign o_hi   = r_hi;
  assign o_lo   = r_lo;

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Directed self-checking bench for hilo_muldiv_unit at WIDTH=32.
module tb_hilo_muldiv_unit;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [2:0]   op = 3'd0;
  logic [W-1:0] src_a = '0;
  logic [W-1:0] src_b = '0;
  logic         flush = 1'b0;
  logic         stall, done;
  logic [W-1:0] hi, lo;

  int n_chk = 0;
  int n_fail = 0;

  hilo_muldiv_unit #(.WIDTH(W)) dut (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_start (start),
    .i_op    (op),
    .i_src_a (src_a),
    .i_src_b (src_b),
    .i_flush (flush),
    .o_stall (stall),
    .o_done  (done),
    .o_hi    (hi),
    .o_lo    (lo)
  );

  always #5 clk = ~clk;

  // Issue one op and count stall cycles up to the done pulse (bounded wait).
  task automatic run_op(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                        output int stalls, output bit got_done);
    stalls = 0;
    got_done = 1'b0;
    @(negedge clk);
    start = 1'b1; op = o; src_a = a; src_b = b;
    #1;
    if (stall) stalls++;
    @(posedge clk);
    #1 start = 1'b0;
    for (int i = 0; i < 100 && !got_done; i++) begin
      @(negedge clk);
      if (done) got_done = 1'b1;
      else if (stall) stalls++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_chk++; if (hi !== 32'h0)  begin n_fail++; $display("FAIL reset_hi got %h exp 0", hi); end
    n_chk++; if (lo !== 32'h0)  begin n_fail++; $display("FAIL reset_lo got %h exp 0", lo); end
    n_chk++; if (stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall got %b exp 0", stall); end
    n_chk++; if (done !== 1'b0)  begin n_fail++; $display("FAIL reset_done got %b exp 0", done); end
    rst = 1'b0;
  endtask

  task automatic test_multu();
    int s; bit d;
    run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, s, d);
    n_chk++; if (d !== 1'b1) begin n_fail++; $display("FAIL multu_done got %b exp 1 (timeout)", d); end
    n_chk++; if (s != 34) begin n_fail++; $display("FAIL multu_stall_cycles got %0d exp 34", s); end
    n_chk++; if (hi !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL multu_hi got %h exp fffffffe", hi); end
    n_chk++; if (lo !== 32'h0000_0001) begin n_fail++; $display("FAIL multu_lo got %h exp 00000001", lo); end
    n_chk++; if (stall !== 1'b0) begin n_fail++; $display("FAIL multu_stall_in_done got %b exp 0", stall); end
    @(negedge clk);
    n_chk++; if (done !== 1'b0) begin n_fail++; $display("FAIL multu_done_width got %b exp 0", done); end
  endtask

  task automatic test_mult();
    int s; bit d;
    run_op(3'd0, 32'hFFFF_FFFD, 32'd7, s, d);
    n_chk++; if (d !== 1'b1) begin n_fail++; $display("FAIL mult_done got %b exp 1 (timeout)", d); end
    n_chk++; if (hi !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL mult_hi got %h exp ffffffff", hi); end
    n_chk++; if (lo !== 32'hFFFF_FFEB) begin n_fail++; $display("FAIL mult_lo got %h exp ffffffeb", lo); end
  endtask

  task automatic test_div();
    int s; bit d;
    run_op(3'd2, 32'hFFFF_FFF9, 32'd2, s, d);
    n_chk++; if (d !== 1'b1) begin n_fail++; $display("FAIL div_done got %b exp 1 (timeout)", d); end
    n_chk++; if (s != 34) begin n_fail++; $display("FAIL div_stall_cycles got %0d exp 34", s); end
    n_chk++; if (lo !== 32'hFFFF_FFFD) begin n_fail++; $display("FAIL div_lo got %h exp fffffffd", lo); end
    n_chk++; if (hi !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL div_hi got %h exp ffffffff", hi); end
    run_op(3'd2, 32'd7, 32'hFFFF_FFFE, s, d);
    n_chk++; if (lo !== 32'hFFFF_FFFD) begin n_fail++; $display("FAIL div_negb_lo got %h exp fffffffd", lo); end
    n_chk++; if (hi !== 32'h0000_0001) begin n_fail++; $display("FAIL div_negb_hi got %h exp 00000001", hi); end
  endtask

  task automatic test_div_ovf();
    int s; bit d;
    run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, s, d);
    n_chk++; if (d !== 1'b1) begin n_fail++; $display("FAIL divovf_done got %b exp 1 (timeout)", d); end
    n_chk++; if (lo !== 32'h8000_0000) begin n_fail++; $display("FAIL divovf_lo got %h exp 80000000", lo); end
    n_chk++; if (hi !== 32'h0) begin n_fail++; $display("FAIL divovf_hi got %h exp 0", hi); end
  endtask

  task automatic test_divu();
    int s; bit d;
    run_op(3'd3, 32'd100, 32'd7, s, d);
    n_chk++; if (d !== 1'b1) begin n_fail++; $display("FAIL divu_done got %b exp 1 (timeout)", d); end
    n_chk++; if (lo !== 32'd14) begin n_fail++; $display("FAIL divu_lo got %h exp 0000000e", lo); end
    n_chk++; if (hi !== 32'd2) begin n_fail++; $display("FAIL divu_hi got %h exp 00000002", hi); end
  endtask

  task automatic test_divz();
    int s; bit d;
    run_op(3'd3, 32'd5, 32'd0, s, d);
    n_chk++; if (d !== 1'b1) begin n_fail++; $display("FAIL divz_done got %b exp 1 (timeout)", d); end
    n_chk++; if (s != 2) begin n_fail++; $display("FAIL divz_stall_cycles got %0d exp 2", s); end
    n_chk++; if (hi !== 32'd5) begin n_fail++; $display("FAIL divz_hi got %h exp 00000005", hi); end
    n_chk++; if (lo !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL divz_lo got %h exp ffffffff", lo); end
  endtask

  task automatic test_mthi_mtlo();
    @(negedge clk);
    start = 1'b1; op = 3'd4; src_a = 32'h1234;
    #1;
    n_chk++; if (stall !== 1'b0) begin n_fail++; $display("FAIL mthi_stall got %b exp 0", stall); end
    @(negedge clk);
    op = 3'd5; src_a = 32'hABCD;
    #1;
    n_chk++; if (stall !== 1'b0) begin n_fail++; $display("FAIL mtlo_stall got %b exp 0", stall); end
    @(negedge clk);
    start = 1'b0;
    n_chk++; if (hi !== 32'h1234) begin n_fail++; $display("FAIL mthi_hi got %h exp 00001234", hi); end
    n_chk++; if (lo !== 32'hABCD) begin n_fail++; $display("FAIL mtlo_lo got %h exp 0000abcd", lo); end
    n_chk++; if (done !== 1'b0) begin n_fail++; $display("FAIL mtx_done got %b exp 0", done); end
  endtask

  task automatic test_undef_op();
    @(negedge clk);
    start = 1'b1; op = 3'd6; src_a = 32'hDEAD_BEEF; src_b = 32'd3;
    #1;
    n_chk++; if (stall !== 1'b0) begin n_fail++; $display("FAIL undef_stall got %b exp 0", stall); end
    @(negedge clk);
    start = 1'b0;
    #1;
    n_chk++; if (hi !== 32'h1234 || lo !== 32'hABCD) begin
      n_fail++; $display("FAIL undef_hilo got %h/%h exp 00001234/0000abcd", hi, lo);
    end
    n_chk++; if (stall !== 1'b0 || done !== 1'b0) begin
      n_fail++; $display("FAIL undef_idle got stall=%b done=%b exp 0/0", stall, done);
    end
  endtask

  task automatic test_flush();
    int s; bit d; int dones;
    @(negedge clk); start = 1'b1; op = 3'd4; src_a = 32'h11;
    @(negedge clk); op = 3'd5; src_a = 32'h22;
    @(negedge clk); op = 3'd0; src_a = 32'd6; src_b = 32'd7;
    @(posedge clk); #1 start = 1'b0;
    repeat (10) @(negedge clk);
    flush = 1'b1;
    #1;
    n_chk++; if (stall !== 1'b0) begin n_fail++; $display("FAIL flush_stall got %b exp 0", stall); end
    @(posedge clk); #1 flush = 1'b0;
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) dones++;
      if (i == 0) begin
        n_chk++; if (stall !== 1'b0) begin n_fail++; $display("FAIL flush_idle_stall got %b exp 0", stall); end
      end
    end
    n_chk++; if (dones != 0) begin n_fail++; $display("FAIL flush_no_done got %0d exp 0", dones); end
    n_chk++; if (hi !== 32'h11) begin n_fail++; $display("FAIL flush_hi got %h exp 00000011", hi); end
    n_chk++; if (lo !== 32'h22) begin n_fail++; $display("FAIL flush_lo got %h exp 00000022", lo); end
    // A flush coinciding with MTHI in IDLE drops the write.
    @(negedge clk); start = 1'b1; op = 3'd4; src_a = 32'hDEAD; flush = 1'b1;
    @(negedge clk); start = 1'b0; flush = 1'b0;
    n_chk++; if (hi !== 32'h11) begin n_fail++; $display("FAIL flush_mthi_hi got %h exp 00000011", hi); end
    run_op(3'd0, 32'd6, 32'd7, s, d);
    n_chk++; if (d !== 1'b1) begin n_fail++; $display("FAIL reissue_done got %b exp 1 (timeout)", d); end
    n_chk++; if (s != 34) begin n_fail++; $display("FAIL reissue_stall_cycles got %0d exp 34", s); end
    n_chk++; if (lo !== 32'd42) begin n_fail++; $display("FAIL reissue_lo got %h exp 0000002a", lo); end
    n_chk++; if (hi !== 32'd0) begin n_fail++; $display("FAIL reissue_hi got %h exp 0", hi); end
  endtask

  task automatic test_reset_mid();
    @(negedge clk); start = 1'b1; op = 3'd2; src_a = 32'd100; src_b = 32'd7;
    @(posedge clk); #1 start = 1'b0;
    repeat (5) @(negedge clk);
    n_chk++; if (stall !== 1'b1) begin n_fail++; $display("FAIL midrst_busy got %b exp 1", stall); end
    rst = 1'b1;
    @(negedge clk);
    n_chk++; if (hi !== 32'h0 || lo !== 32'h0) begin
      n_fail++; $display("FAIL midrst_hilo got %h/%h exp 0/0", hi, lo);
    end
    n_chk++; if (stall !== 1'b0) begin n_fail++; $display("FAIL midrst_stall got %b exp 0", stall); end
    n_chk++; if (done !== 1'b0) begin n_fail++; $display("FAIL midrst_done got %b exp 0", done); end
    rst = 1'b0;
    repeat (40) @(negedge clk);
    n_chk++; if (hi !== 32'h0 || lo !== 32'h0) begin
      n_fail++; $display("FAIL midrst_after got %h/%h exp 0/0", hi, lo);
    end
  endtask

  initial begin
    test_reset();
    test_multu();
    test_mult();
    test_div();
    test_div_ovf();
    test_divu();
    test_divz();
    test_mthi_mtlo();
    test_undef_op();
    test_flush();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/hilo_muldiv_unit.md
Name: hilo_muldiv_unit

Overview:
- Parametrised HI/LO register file with an iterative multiply/divide engine for the MIPS execute stage.
- Executes MULT, MULTU, DIV, DIVU, MTHI and MTLO.
- Stalls the pipeline with a combinational stall flag while a multi-cycle operation runs.
- Supports pipeline flush, so an exception or branch cancel aborts an in-flight operation without corrupting HI/LO.

Parameters:
- WIDTH, 32: operand width and HI/LO register width; must be at least 4.
- CNT_W, $clog2(WIDTH)+1: iteration counter width. Derived; not overridden.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset, synchronous, active-high
- start  in  1  operation request, valid in the current cycle
- op  in  3  operation code; codes are listed under Decomposition
- src_a  in  WIDTH  rs operand: multiplicand, dividend, or MTHI/MTLO data
- src_b  in  WIDTH  rt operand: multiplier or divisor
- flush  in  1  abort any operation in flight
- stall  out  1  combinational; pipeline must hold while it is high
- done  out  1  one-cycle pulse; HI/LO results are valid from this cycle
- hi  out  WIDTH  HI register
- lo  out  WIDTH  LO register

Behaviour:
- Reset: state=IDLE, hi=0, lo=0, done=0, counter=0, stall=0. Reset mid-operation discards all work.
- FSM states: IDLE, MUL, DIV, FIN.
- IDLE + start + MTHI: hi<=src_a at the next edge. No stall, no done.
- IDLE + start + MTLO: lo<=src_a at the next edge. No stall, no done.
- IDLE + start + MULT/MULTU/DIV/DIVU:
  - stall=1 in that same cycle.
  - Latch |src_a| and |src_b| (raw values for the unsigned ops), plus the result signs.
  - Next state MUL or DIV, counter=0.
- MUL: radix-2 shift-add, one bit per cycle over a 2*WIDTH accumulator.
- DIV: radix-2 restoring division, one quotient bit per cycle.
- MUL/DIV: after WIDTH iterations, go to FIN.
- FIN: apply sign correction, write hi/lo at the exiting edge, go to IDLE, done<=1 for exactly one cycle.
- Stall timing: stall is high in the start cycle, all WIDTH MUL/DIV cycles and the FIN cycle, i.e. WIDTH+2 cycles (34 at WIDTH=32). stall=0 in the done cycle.
- Arithmetic:
  - MULT: {hi,lo} = signed 2*WIDTH product.
  - MULTU: {hi,lo} = unsigned 2*WIDTH product.
  - DIV: lo = quotient truncated toward zero; hi = remainder with the sign of the dividend.
  - DIVU: unsigned quotient and remainder.
  - Most-negative / -1: lo = 0x80000000 (wraps), hi = 0.
- Divide by zero (DIV or DIVU with src_b=0): skip iteration, go IDLE->FIN directly. Result hi=src_a, lo=all-ones. Stall lasts 2 cycles.
- Flush:
  - Highest priority below rst.
  - Any state goes to IDLE at the next edge; hi/lo unchanged; done=0.
  - stall is forced to 0 in any cycle where flush=1.
  - flush together with start in IDLE: the request is dropped, including MTHI/MTLO.
- start while not IDLE: ignored. The stalled pipeline holds the instruction, so it is not re-issued.
- Undefined op codes: ignored, with no state change.
- start low: HI/LO hold their values indefinitely.

Decomposition:
- Shared header defines.vh gets:
  - Op codes: MD_MULT=3'd0, MD_MULTU=3'd1, MD_DIV=3'd2, MD_DIVU=3'd3, MD_MTHI=3'd4, MD_MTLO=3'd5.
  - FSM state encodings.
- maindec's HLwrite, together with funct, drives start/op through a small mapping in the decode stage. That mapping is not part of this block.
- One sub-module, muldiv_iter_core:
  - Contains the combinational single-step datapath: shift-add step and restoring subtract step, parametrised by WIDTH.
  - The parent owns the FSM, counter, sign handling and HI/LO.

Test Plan:
- MULTU 0xFFFFFFFF x 0xFFFFFFFF -> stall high 34 cycles, then hi=0xFFFFFFFE, lo=0x00000001, done pulses 1 cycle.
- MULT -3 x 7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- DIV -7 / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIVU 100 / 7 -> lo=14, hi=2.
- DIVU 5 / 0 -> 2 stall cycles, hi=5, lo=0xFFFFFFFF.
- MTHI 0x1234 then MTLO 0xABCD on consecutive cycles -> hi=0x1234, lo=0xABCD, stall never asserted.
- Start MULT 6x7 with hi/lo preloaded to 0x11/0x22, flush at iteration 10 -> stall drops that cycle, FSM returns to IDLE, hi=0x11, lo=0x22, no done. A following MULT 6x7 completes with lo=42.
- Reset asserted mid-DIV -> next cycle hi=lo=0, stall=0, done=0.
